// File: rtl/ai_best_match_if.sv
// Bundles the accumulator-side sum stream, the pass control inputs and the
// match result outputs of the best-match stage into one port group.
interface ai_best_match_if #(
  parameter int SUM_W = 32,
  parameter int ID_W  = 5
);
  logic             init;
  logic [ID_W-1:0]  templ_last;
  logic [SUM_W-1:0] reject_thr;
  logic [SUM_W-1:0] sum_in;
  logic             sum_rdy;
  logic [ID_W-1:0]  best_id;
  logic [SUM_W-1:0] best_sum;
  logic             match_valid;
  logic             match_reject;
  logic             busy;
  logic             stray_err;

  // Upstream side: starts passes, streams sums and consumes the result.
  modport master (
    output init, templ_last, reject_thr, sum_in, sum_rdy,
    input  best_id, best_sum, match_valid, match_reject, busy, stray_err
  );

  // Best-match stage side.
  modport slave (
    input  init, templ_last, reject_thr, sum_in, sum_rdy,
    output best_id, best_sum, match_valid, match_reject, busy, stray_err
  );
endinterface

// File: rtl/ai_best_match.sv
// Minimum-distance template selector. Tracks the smallest distance sum and
// its template index over one classification pass, then reports the winner,
// its distance and a reject flag for one cycle. Results hold until the next
// pass starts.
module ai_best_match #(
  parameter int SUM_W = 32,
  parameter int ID_W  = 5
) (
  input  logic           clk,
  input  logic           rst,
  ai_best_match_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [ID_W-1:0]  idx, idx_n;
  logic [ID_W-1:0]  last_q, last_n;
  logic [SUM_W-1:0] thr_q, thr_n;
  logic [ID_W-1:0]  best_id_q, best_id_n;
  logic [SUM_W-1:0] best_sum_q, best_sum_n;
  logic             valid_q, valid_n;
  logic             reject_q, reject_n;
  logic             stray_q, stray_n;
  logic             busy_q;

  // Next-state and next-value logic; init always wins over any sum that
  // arrives in the same cycle, so that sum is simply never looked at.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    last_n     = last_q;
    thr_n      = thr_q;
    best_id_n  = best_id_q;
    best_sum_n = best_sum_q;
    valid_n    = 1'b0;
    reject_n   = reject_q;
    stray_n    = stray_q;

    if (bus.init) begin
      state_n    = COLLECT;
      idx_n      = '0;
      last_n     = bus.templ_last;
      thr_n      = bus.reject_thr;
      best_id_n  = '0;
      best_sum_n = '1;
      reject_n   = 1'b0;
      stray_n    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.sum_rdy) begin
            stray_n = 1'b1;
          end
        end
        COLLECT: begin
          if (bus.sum_rdy) begin
            if (bus.sum_in < best_sum_q) begin
              best_sum_n = bus.sum_in;
              best_id_n  = idx;
            end
            if (idx == last_q) begin
              state_n  = DONE;
              valid_n  = 1'b1;
              reject_n = (best_sum_n > thr_q);
            end else begin
              idx_n = idx + 1'b1;
            end
          end
        end
        DONE: begin
          state_n = IDLE;
          if (bus.sum_rdy) begin
            stray_n = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      last_q     <= '0;
      thr_q      <= '0;
      best_id_q  <= '0;
      best_sum_q <= '1;
      valid_q    <= 1'b0;
      reject_q   <= 1'b0;
      stray_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      last_q     <= last_n;
      thr_q      <= thr_n;
      best_id_q  <= best_id_n;
      best_sum_q <= best_sum_n;
      valid_q    <= valid_n;
      reject_q   <= reject_n;
      stray_q    <= stray_n;
      busy_q     <= (state_n != IDLE);
    end
  end

  assign bus.best_id      = best_id_q;
  assign bus.best_sum     = best_sum_q;
  assign bus.match_valid  = valid_q;
  assign bus.match_reject = reject_q;
  assign bus.busy         = busy_q;
  assign bus.stray_err    = stray_q;

endmodule

// File: tb/tb_ai_best_match.sv
// Directed bench for the best-match stage. Stimulus pushes the hand-computed
// result of each pass into a scoreboard; a monitor pops and compares on every
// match_valid pulse, so a missing, extra or wrong result is reported.
module tb_ai_best_match;
  localparam int SUM_W = 32;
  localparam int ID_W  = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  ai_best_match_if #(.SUM_W(SUM_W), .ID_W(ID_W)) bus ();

  ai_best_match #(.SUM_W(SUM_W), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [ID_W-1:0]  id;
    logic [SUM_W-1:0] sum;
    logic             rej;
  } exp_t;

  exp_t             sb[$];
  int               n_checks = 0;
  int               n_pass   = 0;
  logic [SUM_W-1:0] sv[$];

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Deliver one distance sum for one cycle.
  task automatic applyStimulus(input logic [SUM_W-1:0] s);
    bus.sum_in  = s;
    bus.sum_rdy = 1'b1;
    tick();
    bus.sum_rdy = 1'b0;
  endtask

  task automatic start_pass(input logic [ID_W-1:0] last, input logic [SUM_W-1:0] thr);
    bus.init       = 1'b1;
    bus.templ_last = last;
    bus.reject_thr = thr;
    tick();
    bus.init = 1'b0;
  endtask

  task automatic expect_result(input logic [ID_W-1:0] id, input logic [SUM_W-1:0] s,
                               input logic rej);
    exp_t e;
    e.id  = id;
    e.sum = s;
    e.rej = rej;
    sb.push_back(e);
  endtask

  task automatic send_sums();
    foreach (sv[i]) applyStimulus(sv[i]);
  endtask

  // Bounded wait for all expected results to be consumed by the monitor.
  task automatic wait_drained(input string name);
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      checkOutput({name, "_timeout"}, 64'(sb.size()), 0);
      sb.delete();
    end
  endtask

  // Monitor: every match_valid pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (bus.match_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_match_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("best_id", 64'(bus.best_id), 64'(e.id));
        checkOutput("best_sum", 64'(bus.best_sum), 64'(e.sum));
        checkOutput("match_reject", 64'(bus.match_reject), 64'(e.rej));
      end
    end
  end

  initial begin
    bus.init       = 1'b0;
    bus.templ_last = '0;
    bus.reject_thr = '0;
    bus.sum_in     = '0;
    bus.sum_rdy    = 1'b0;

    // Reset values
    rst = 1'b0;
    repeat (3) tick();
    checkOutput("rst_best_id", 64'(bus.best_id), 0);
    checkOutput("rst_best_sum", 64'(bus.best_sum), 64'hFFFF_FFFF);
    checkOutput("rst_match_valid", 64'(bus.match_valid), 0);
    checkOutput("rst_match_reject", 64'(bus.match_reject), 0);
    checkOutput("rst_busy", 64'(bus.busy), 0);
    checkOutput("rst_stray_err", 64'(bus.stray_err), 0);
    rst = 1'b1;
    tick();

    // Basic pass: minimum at index 1
    expect_result(5'd1, 32'd120, 1'b0);
    start_pass(5'd3, 32'd1000);
    checkOutput("busy_collect", 64'(bus.busy), 1);
    sv = {32'd500, 32'd120, 32'd300, 32'd800};
    send_sums();
    checkOutput("busy_done", 64'(bus.busy), 1);
    tick();
    checkOutput("busy_idle", 64'(bus.busy), 0);
    checkOutput("hold_best_id", 64'(bus.best_id), 1);
    checkOutput("hold_best_sum", 64'(bus.best_sum), 120);
    wait_drained("pass1");

    // Ties keep the lower index
    expect_result(5'd2, 32'd90, 1'b0);
    start_pass(5'd2, 32'd1000);
    sv = {32'd200, 32'd200, 32'd90};
    send_sums();
    tick();
    expect_result(5'd0, 32'd90, 1'b0);
    start_pass(5'd2, 32'd1000);
    sv = {32'd90, 32'd90, 32'd300};
    send_sums();
    tick();
    wait_drained("tie");

    // Reject threshold is strict; captured values ignore later changes
    expect_result(5'd0, 32'd150, 1'b1);
    start_pass(5'd1, 32'd100);
    sv = {32'd150, 32'd400};
    send_sums();
    tick();
    expect_result(5'd0, 32'd150, 1'b0);
    start_pass(5'd1, 32'd150);
    bus.reject_thr = 32'd0;
    bus.templ_last = 5'd0;
    send_sums();
    tick();
    wait_drained("reject");

    // Mid-pass init aborts silently
    expect_result(5'd3, 32'd40, 1'b0);
    start_pass(5'd3, 32'd1000);
    sv = {32'd10, 32'd20};
    send_sums();
    start_pass(5'd3, 32'd1000);
    sv = {32'd70, 32'd60, 32'd50, 32'd40};
    send_sums();
    tick();
    wait_drained("restart");

    // Stray sum in IDLE, then init+sum in the same cycle drops that sum
    applyStimulus(32'd7);
    checkOutput("stray_idle", 64'(bus.stray_err), 1);
    expect_result(5'd1, 32'd200, 1'b0);
    bus.sum_in     = 32'd5;
    bus.sum_rdy    = 1'b1;
    start_pass(5'd1, 32'd1000);
    bus.sum_rdy    = 1'b0;
    checkOutput("stray_cleared_by_init", 64'(bus.stray_err), 0);
    sv = {32'd300, 32'd200};
    send_sums();
    // Sum arriving in DONE is stray and changes nothing else
    applyStimulus(32'd1);
    checkOutput("stray_done", 64'(bus.stray_err), 1);
    checkOutput("stray_done_best_sum", 64'(bus.best_sum), 200);
    wait_drained("stray");

    // Largest pass: idx reaches 31 without wrapping
    expect_result(5'd31, 32'd690, 1'b1);
    start_pass(5'd31, 32'd600);
    sv.delete();
    for (int i = 0; i < 32; i++) sv.push_back(32'(1000 - 10 * i));
    send_sums();
    tick();
    wait_drained("max_pass");

    // All-ones single sum keeps id 0 / all-ones
    expect_result(5'd0, 32'hFFFF_FFFF, 1'b1);
    start_pass(5'd0, 32'd1000);
    applyStimulus(32'hFFFF_FFFF);
    tick();
    wait_drained("all_ones");

    // Reset mid-pass: back to reset values, no result
    start_pass(5'd3, 32'd1000);
    sv = {32'd1, 32'd2};
    send_sums();
    rst = 1'b0;
    tick();
    checkOutput("midrst_best_id", 64'(bus.best_id), 0);
    checkOutput("midrst_best_sum", 64'(bus.best_sum), 64'hFFFF_FFFF);
    checkOutput("midrst_busy", 64'(bus.busy), 0);
    checkOutput("midrst_match_valid", 64'(bus.match_valid), 0);
    rst = 1'b1;
    sv = {32'd3, 32'd4};
    send_sums();
    repeat (3) tick();
    checkOutput("midrst_stray_after", 64'(bus.stray_err), 1);
    checkOutput("midrst_busy_after", 64'(bus.busy), 0);

    wait_drained("final");
    checkOutput("scoreboard_empty", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
